multdiv_issue_ctrl: RTL

Processor-side initiator for the multi-cycle multiply/divide unit. Takes a mult/div instruction from the execute stage, latches operands and destination, and issues a one-cycle `ctrl_MULT`/`ctrl_DIV` start pulse. While the unit works it holds the operands stable and stalls the pipeline. On `data_resultRDY` it captures the result, or the exception, and presents a one-cycle writeback to the register file.

---
 rtl/multdiv_issue_pkg.sv | 23 ++
 rtl/md_wait_counter.sv | 39 +++
 rtl/multdiv_issue_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/multdiv_issue_pkg.sv
// Shared types and default constants for the mult/div issue controller.
// The wait-counter width helper keeps both modules in agreement.
package multdiv_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } md_state_e;

  localparam int unsigned DEF_TIMEOUT       = 40;
  localparam int unsigned DEF_RSTATUS_REG   = 30;
  localparam int unsigned DEF_MULT_EXC_CODE = 4;
  localparam int unsigned DEF_DIV_EXC_CODE  = 5;
  localparam int unsigned DEF_TIMEOUT_CODE  = 6;

  // Bits needed to hold 0..limit; at least one bit so a zero limit still elaborates.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/md_wait_counter.sv
// Saturating wait counter with synchronous clear and enable.
// hit is high while the count sits at TIMEOUT.
module md_wait_counter
  import multdiv_issue_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int unsigned   CW    = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit = (count_q == LIMIT);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the multi-cycle mult/div unit: latches the request,
// pulses the start line, stalls the pipeline and returns one writeback.
module multdiv_issue_ctrl
  import multdiv_issue_pkg::*;
#(
  parameter int unsigned TIMEOUT       = DEF_TIMEOUT,
  parameter int unsigned RSTATUS_REG   = DEF_RSTATUS_REG,
  parameter int unsigned MULT_EXC_CODE = DEF_MULT_EXC_CODE,
  parameter int unsigned DIV_EXC_CODE  = DEF_DIV_EXC_CODE,
  parameter int unsigned TIMEOUT_CODE  = DEF_TIMEOUT_CODE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_is_div,
  input  logic [31:0] req_opA,
  input  logic [31:0] req_opB,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        timeout_err
);

  md_state_e   state_q, state_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_div_q, is_div_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        timeout_err_q, timeout_err_d;
  logic        cnt_hit;

  md_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait_counter (
    .clock (clock),
    .reset (reset),
    .clr   (state_q == ST_ISSUE),
    .en    (state_q == ST_WAIT),
    .hit   (cnt_hit)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: each always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (md_resultRDY || cnt_hit) state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    wb_valid  = 1'b0;
    unique case (state_q)
      ST_IDLE:  stall = req_valid;
      ST_ISSUE: begin
        stall     = 1'b1;
        ctrl_DIV  = is_div_q;
        ctrl_MULT = ~is_div_q;
      end
      ST_WAIT:  stall = 1'b1;
      ST_WB:    wb_valid = 1'b1;
      default:  stall = 1'b0;
    endcase
  end

  // Request latch and writeback capture; a ready result outranks a same-cycle timeout.
  always_comb begin
    opa_d         = opa_q;
    opb_d         = opb_q;
    rd_d          = rd_q;
    is_div_d      = is_div_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    timeout_err_d = timeout_err_q;
    if ((state_q == ST_IDLE) && req_valid) begin
      opa_d    = req_opA;
      opb_d    = req_opB;
      rd_d     = req_rd;
      is_div_d = req_is_div;
    end
    if (state_q == ST_WAIT) begin
      if (md_resultRDY) begin
        if (md_exception) begin
          wb_rd_d   = 5'(RSTATUS_REG);
          wb_data_d = is_div_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
        end else begin
          wb_rd_d   = rd_q;
          wb_data_d = md_result;
        end
      end else if (cnt_hit) begin
        wb_rd_d       = 5'(RSTATUS_REG);
        wb_data_d     = 32'(TIMEOUT_CODE);
        timeout_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      opa_q         <= '0;
      opb_q         <= '0;
      rd_q          <= '0;
      is_div_q      <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      rd_q          <= rd_d;
      is_div_q      <= is_div_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign md_opA      = opa_q;
  assign md_opB      = opb_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign timeout_err = timeout_err_q;

endmodule
